context_ent: RTL and testbench

//  Sequential 8-bit arithmetic context unit. On a start request it latches

---
 rtl/ctx_pkg.sv | 18 +
 rtl/context_ent_if.sv | 27 ++
 rtl/ctx_divider.sv | 56 +++++
 rtl/context_ent.sv | 88 ++++++++
 tb/tb_context_ent.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/ctx_pkg.sv
// Shared types and constants for the context_ent arithmetic unit.
package ctx_pkg;

  localparam int W = 8;
  localparam logic [W-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DIV,
    FIN
  } state_t;

  function automatic logic [W-1:0] add_wrap(input logic [W-1:0] x, input logic [W-1:0] y);
    return x + y;
  endfunction

endpackage

// File: rtl/context_ent_if.sv
// Start/done handshake and result bus of context_ent.
interface context_ent_if
  import ctx_pkg::*;
#(
  parameter int DATA_W = W
);

  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] xout;
  logic [DATA_W-1:0] d;
  logic              div_zero;

  modport master (
    output start, a, b,
    input  busy, done, xout, d, div_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, xout, d, div_zero
  );

endinterface

// File: rtl/ctx_divider.sv
// Restoring unsigned divider, one quotient bit per clock; B==0 yields all-ones.
module ctx_divider
  import ctx_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] q,
  output logic         div_zero,
  output logic         done
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);

  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic [W-1:0]  dsr;
  logic [CW-1:0] cnt;
  logic          dz;
  logic [W:0]    shifted;
  logic          fit;

  assign shifted = {rem, quo[W-1]};
  assign fit     = (shifted >= {1'b0, dsr});

  // Asserted on the edge that produces the last quotient bit, so the caller
  // can move on in lockstep with the final iteration.
  assign done     = (cnt == CW'(1));
  assign q        = dz ? DIV_ZERO_Q : quo;
  assign div_zero = dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
      dz  <= (divisor == '0);
      cnt <= CNT_INIT;
    end else if (cnt != '0) begin
      // Partial remainder is always below the divisor, so W bits suffice.
      rem <= fit ? (shifted[W-1:0] - dsr) : shifted[W-1:0];
      quo <= {quo[W-2:0], fit};
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/context_ent.sv
// Sequential arithmetic context: xout = (A-B) + low(A*B), d accumulates A/B.
module context_ent
  import ctx_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  context_ent_if.slave  bus
);

  state_t       state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] c_r;
  logic [W-1:0] xout_r;
  logic [W-1:0] d_r;
  logic         dz_r;
  logic         busy_r;
  logic         done_r;

  logic         div_start;
  logic         div_done;
  logic         div_dz;
  logic [W-1:0] q;
  logic [W-1:0] prod_lo;

  assign div_start = (state == SUB);
  assign prod_lo   = a_r * b_r;

  ctx_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a_r),
    .divisor  (b_r),
    .q        (q),
    .div_zero (div_dz),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= '0;
      xout_r <= '0;
      d_r    <= '0;
      dz_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            busy_r <= 1'b1;
            state  <= SUB;
          end
        end
        SUB: begin
          c_r   <= a_r - b_r;
          state <= DIV;
        end
        DIV: begin
          if (div_done) state <= FIN;
        end
        FIN: begin
          d_r    <= add_wrap(d_r, q);
          xout_r <= add_wrap(c_r, prod_lo);
          dz_r   <= div_dz;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.xout     = xout_r;
  assign bus.d        = d_r;
  assign bus.div_zero = dz_r;

endmodule

// File: tb/tb_context_ent.sv
// Directed bench for context_ent: hand-computed results, latency, ignore-while-busy, mid-op reset.
module tb_context_ent;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   lat;
  int   ndone;

  context_ent_if bus ();

  context_ent dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Launch one operation; mode 1 pulses a competing start at T+3.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int mode, output int l);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    l = 0;
    for (int n = 1; n <= 20; n++) begin
      if (mode == 1 && n == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        l = n;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_xout", {24'd0, bus.xout}, 32'd0);
    check("rst_d", {24'd0, bus.d}, 32'd0);
    check("rst_dz", {31'd0, bus.div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 20-3=17, 20*3=60, 20/3=6
    run_op(8'd20, 8'd3, 0, lat);
    check("op1_latency", lat, 32'd10);
    check("op1_xout", {24'd0, bus.xout}, 32'd77);
    check("op1_d", {24'd0, bus.d}, 32'd6);
    check("op1_dz", {31'd0, bus.div_zero}, 32'd0);
    check("op1_busy", {31'd0, bus.busy}, 32'd0);

    // back-to-back on the done cycle: 3-20 wraps to 239, +60 -> 43, q=0
    run_op(8'd3, 8'd20, 0, lat);
    check("op2_latency", lat, 32'd10);
    check("op2_xout", {24'd0, bus.xout}, 32'd43);
    check("op2_d", {24'd0, bus.d}, 32'd6);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("xout_hold", {24'd0, bus.xout}, 32'd43);

    // c=0, 256 truncates to 0, q=1
    run_op(8'd16, 8'd16, 0, lat);
    check("op3_xout", {24'd0, bus.xout}, 32'd0);
    check("op3_d", {24'd0, bus.d}, 32'd7);

    // divide by zero: q=255, d=(7+255)%256=6, xout=5+0
    run_op(8'd5, 8'd0, 0, lat);
    check("dz_latency", lat, 32'd10);
    check("dz_xout", {24'd0, bus.xout}, 32'd5);
    check("dz_d", {24'd0, bus.d}, 32'd6);
    check("dz_flag", {31'd0, bus.div_zero}, 32'd1);

    // start while busy ignored: 9-4=5, 36, 9/4=2 -> xout 41, d 8
    run_op(8'd9, 8'd4, 1, lat);
    check("ign_latency", lat, 32'd10);
    check("ign_xout", {24'd0, bus.xout}, 32'd41);
    check("ign_d", {24'd0, bus.d}, 32'd8);
    check("ign_dz", {31'd0, bus.div_zero}, 32'd0);
    count_done(12, ndone);
    check("ign_no_extra_done", ndone, 32'd0);
    check("ign_idle_busy", {31'd0, bus.busy}, 32'd0);

    // reset mid-operation at T+4
    bus.a     = 8'd50;
    bus.b     = 8'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_xout", {24'd0, bus.xout}, 32'd0);
    check("mid_rst_d", {24'd0, bus.d}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    check("mid_rst_dz", {31'd0, bus.div_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(12, ndone);
    check("mid_rst_no_done", ndone, 32'd0);

    // recovery: 7-2=5, 14 -> 19, q=3, d from 0
    run_op(8'd7, 8'd2, 0, lat);
    check("rec_latency", lat, 32'd10);
    check("rec_xout", {24'd0, bus.xout}, 32'd19);
    check("rec_d", {24'd0, bus.d}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
